uart_tx_arb: RTL
================

Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares the single uart_txd transmitter between NUM_REQ byte requesters.
- Captures the winning requester's byte and issues a one-cycle start pulse to the transmitter.
- Holds the data stable for the whole frame and waits for the transmitter's done pulse before serving the next request.
- Sits between client logic and uart_txd. Its tx-start/tx-data outputs drive uart_txd i_tx_start/i_data; uart_txd o_tx_done returns on i_tx_done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, owner index width; must equal clog2(NUM_REQ)
TIMEOUT_CYCLES, 65536, watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_req  input  NUM_REQ  per-requester level request; held until matching o_gnt bit
i_req_data  input  NUM_REQ*8  requester k's byte on bits [8k+7:8k]
o_gnt  output  NUM_REQ  one-hot one-cycle grant; byte captured
o_tx_start  output  1  one-cycle start pulse to uart_txd
o_tx_data  output  8  byte to uart_txd, stable from start until done
i_tx_done  input  1  uart_txd frame-complete pulse
o_busy  output  1  high whenever state != IDLE
o_owner  output  IDX_W  index of the current/last granted requester
o_timeout  output  1  one-cycle watchdog abort pulse (0 when feature is off)

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr pointer=0. o_gnt=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_owner=0, o_timeout=0. Reset mid-frame aborts without a done wait; uart_txd is reset by the same rst_n.
- All outputs are registered.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE, cycle N, with i_req != 0:
  - Winner = first set bit searching upward from the pointer, wrapping at NUM_REQ-1 to 0.
  - Load o_tx_data from the winner's slice; set o_owner = winner; set the pointer to (winner+1) mod NUM_REQ.
  - Go to START.
- IDLE with i_req == 0: stay in IDLE; outputs are unchanged except the pulses, which are 0.
- START, cycle N+1: o_tx_start=1 and o_gnt[winner]=1 for exactly this cycle. Go to WAIT_DONE. Request-to-start latency is 1 cycle.
- WAIT_DONE: hold o_tx_data and o_owner.
  - i_tx_done=1 → GAP.
  - i_tx_done in START, GAP or IDLE is ignored (spurious).
- GAP: one idle cycle so uart_txd returns to idle, then IDLE. Minimum spacing is done → next o_tx_start = 3 cycles.
- Request rules:
  - Requests are sampled only in IDLE.
  - A requester may deassert before its grant; this is legal and it loses its turn silently.
  - The requester must deassert i_req in the cycle after o_gnt, or it is treated as a new request.
- A requester holding i_req continuously cannot be served twice in a row while another requester is waiting.
- Simultaneous i_req change and selection: the IDLE-cycle sample wins.
- i_req_data of non-winners is ignored.

Optional Feature:
UART_ARB_TIMEOUT_EN.
- Defined: a 32-bit counter clears on entry to WAIT_DONE and increments every WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without i_tx_done: pulse o_timeout for 1 cycle, go to GAP, then IDLE.
  - The pointer keeps its already-advanced value and no retry is made.
  - i_tx_done arriving in the same cycle as the limit counts as done; o_timeout is not pulsed.
- Undefined: no counter; o_timeout is tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
1. Single request: i_req=4'b0100, slice2=8'hA5 → next cycle o_tx_start=1, o_gnt=4'b0100, o_tx_data=8'hA5, o_owner=2; o_busy high until 2 cycles after i_tx_done.
2. Round-robin fairness: i_req=4'b1111 held, data 8'h10/11/12/13, each requester dropping its req after grant then reasserting → grant order 0,1,2,3,0; o_tx_data sequence 10,11,12,13,10.
3. Non-repeat under contention: i_req=4'b0011 held continuously → grants alternate 0,1,0,1.
4. Spurious done: i_tx_done pulsed in IDLE and in START → no state change; frame completes only on the done pulse in WAIT_DONE; done → next o_tx_start gap is exactly 3 cycles.
5. Reset mid-frame: rst_n low during WAIT_DONE with o_tx_data=8'h5A → all outputs 0 immediately (async); after release, i_req=4'b1000 is granted with pointer starting from 0.
6. Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): grant, then withhold i_tx_done → o_timeout pulses 16 cycles after entering WAIT_DONE; o_busy drops 1 cycle later; the next request is granted normally.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_txd between NUM_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that pulses o_timeout.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [IDX_W-1:0]     o_owner,
  output logic                 o_timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 2) begin : g_bad
    $error("uart_tx_arb: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StGap} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 start_q, start_d;
  logic [7:0]           data_q, data_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic                 found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     win_nxt;
  logic                 wd_expire;

  // Winner search: first set request at or above the pointer, wrapping to 0.
  always_comb begin
    logic [IDX_W-1:0] idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && i_req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    win_nxt = IDX_W'((32'(win_idx) + 32'd1) % NUM_REQ);
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q;

  // A done arriving on the limit cycle wins over the watchdog.
  assign wd_expire = (state_q == StWaitDone) && !i_tx_done &&
                     (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StStart) begin
      cnt_d = '0;
    end else if (state_q == StWaitDone) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= wd_expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (found) state_d = StStart;
      StStart:    state_d = StWaitDone;
      StWaitDone: if (i_tx_done || wd_expire) state_d = StGap;
      StGap:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output next-state logic; every output is registered below.
  always_comb begin
    gnt_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = (state_d != StIdle);
    if (state_q == StIdle && found) begin
      gnt_d[win_idx] = 1'b1;
      start_d        = 1'b1;
      data_d         = i_req_data[{win_idx, 3'b000} +: 8];
      owner_d        = win_idx;
      ptr_d          = win_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_owner    = owner_q;
  assign o_busy     = busy_q;

endmodule
